bcd_to_binary_seq: RTL

- Sequential BCD-to-binary converter for the egg timer's set-time entry path.
- Takes two BCD digits (tens and ones) captured from the user setpoint.
- Produces the binary count value that the countdown counter loads.
- Implements iterative reverse double-dabble: one shift-and-correct step per clock, with a start/busy/done handshake.

---
 rtl/egg_timer_pkg.sv | 21 ++
 rtl/bcd_to_binary_seq_if.sv | 29 ++
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/bcd_to_binary_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared egg-timer definitions: converter FSM states, BCD digit constants,
// and the default largest legal setpoint.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } conv_state_e;

    localparam int unsigned BCD_DIGIT_W     = 4;
    localparam int unsigned BCD_DIGIT_MAX   = 9;
    localparam int unsigned BCD_ADJ_THRESH  = 8;
    localparam int unsigned BCD_ADJ_VAL     = 3;
    localparam int unsigned MAX_VAL_DEFAULT = 59;

    function automatic logic bcd_digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > BCD_DIGIT_W'(BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake/data bundle between the setpoint entry logic and the BCD-to-binary
// converter. BCD_CHECK_EN adds the bcd_err status line.
interface bcd_to_binary_seq_if
    import egg_timer_pkg::*;
#(
    parameter int unsigned BIN_W = 7
);
    logic                   start;
    logic [BCD_DIGIT_W-1:0] bcd2;
    logic [BCD_DIGIT_W-1:0] bcd1;
    logic                   busy;
    logic                   done;
    logic [BIN_W-1:0]       q;
    logic                   over_max;
`ifdef BCD_CHECK_EN
    logic                   bcd_err;

    modport master (output start, bcd2, bcd1,
                    input  busy, done, q, over_max, bcd_err);
    modport slave  (input  start, bcd2, bcd1,
                    output busy, done, q, over_max, bcd_err);
`else
    modport master (output start, bcd2, bcd1,
                    input  busy, done, q, over_max);
    modport slave  (input  start, bcd2, bcd1,
                    output busy, done, q, over_max);
`endif

endinterface

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble nibble correction: values >= 8 get 3 subtracted.
module bcd_digit_adjust
    import egg_timer_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH))
                   ? digit_i - BCD_DIGIT_W'(BCD_ADJ_VAL)
                   : digit_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Two-digit BCD to binary converter, one reverse double-dabble step per clock.
// Optional macro BCD_CHECK_EN: reject digits > 9 with bcd_err and q = 0.
module bcd_to_binary_seq
    import egg_timer_pkg::*;
#(
    parameter int unsigned BIN_W   = 7,
    parameter int unsigned MAX_VAL = MAX_VAL_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    bcd_to_binary_seq_if.slave bus
);

    localparam int unsigned BCD_W = 2 * BCD_DIGIT_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q;
    logic [BCD_W-1:0] bcd_sr_q;
    logic [BCD_W-1:0] bcd_shift;
    logic [BCD_W-1:0] bcd_sr_d;
    logic [BIN_W-1:0] bin_sr_q;
    logic [BIN_W-1:0] bin_sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [BIN_W-1:0] q_q;
    logic             over_max_q;

    // The BCD register's LSB falls into the binary register's MSB each step
    assign bcd_shift = {1'b0, bcd_sr_q[BCD_W-1:1]};
    assign bin_sr_d  = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};

    for (genvar g = 0; g < 2; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_sr_d[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_CHECK_EN
    logic digits_bad_c;
    logic err_pend_q;
    logic bcd_err_q;

    assign digits_bad_c = bcd_digit_invalid(bus.bcd2) || bcd_digit_invalid(bus.bcd1);
    assign bus.bcd_err  = bcd_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bcd_sr_q   <= '0;
            bin_sr_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            over_max_q <= 1'b0;
`ifdef BCD_CHECK_EN
            err_pend_q <= 1'b0;
            bcd_err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bcd_sr_q <= {bus.bcd2, bus.bcd1};
                        bin_sr_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
`ifdef BCD_CHECK_EN
                        err_pend_q <= digits_bad_c;
                        if (digits_bad_c) begin
                            bcd_sr_q <= '0;
                            state_q  <= FINISH;
                        end
`endif
                    end
                end
                SHIFT: begin
                    bcd_sr_q <= bcd_sr_d;
                    bin_sr_q <= bin_sr_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    q_q        <= bin_sr_q;
                    over_max_q <= (bin_sr_q > BIN_W'(MAX_VAL));
`ifdef BCD_CHECK_EN
                    bcd_err_q  <= err_pend_q;
                    if (err_pend_q) begin
                        q_q        <= '0;
                        over_max_q <= 1'b0;
                    end
`endif
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.q        = q_q;
    assign bus.over_max = over_max_q;

endmodule
